// File: rtl/cs_pkg.sv
// Shared definitions for the command-frame scheduler: state codes, default
// frame/timeout settings and the saturating increment used by its counters.
package cs_pkg;

  typedef enum logic [3:0] {
    SC_IDLE  = 4'd0,
    SC_ARM   = 4'd1,
    SC_WAIT  = 4'd2,
    SC_EVAL  = 4'd3,
    SC_RELS  = 4'd4,
    SC_HOLD  = 4'd5,
    SC_RECOV = 4'd6,
    SC_DRAIN = 4'd7
  } state_e;

  localparam logic [11:0] FRAME_LEN_DEF = 12'd11;
  localparam logic [15:0] TIMEOUT_DEF   = 16'd4096;
  localparam logic [3:0]  GAP_DEF       = 4'd4;

  // Counters narrower than 16 bits pass their own all-ones value as max.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max);
    return (v >= max) ? max : v + 16'd1;
  endfunction

endpackage

// File: rtl/cmd_sched_sat_cnt.sv
// Saturating event counter (W <= 16) with asynchronous active-low clear.
module sat_cnt
  import cs_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ALL1 = '1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = W'(sat_inc(16'(cnt_q), 16'(ALL1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cmd_sched.sv
// Command-frame parser sequencer: starts the parser on a full frame, classifies
// the result, and recovers a hung parser with a reset pulse and FIFO drain.
module cmd_sched
  import cs_pkg::*;
#(
  parameter logic [11:0] FRAME_LEN = FRAME_LEN_DEF,
  parameter logic [15:0] TIMEOUT   = TIMEOUT_DEF,
  parameter logic [3:0]  GAP       = GAP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] fifoc_cnt,
  output logic        fifoc_drain,
  output logic        prs_fs,
  input  logic        prs_fd,
  input  logic        prs_err,
  output logic        prs_rst,
  output logic [11:0] data_len,
  output logic        cfg_stb,
  output logic        busy,
  output logic [15:0] ok_cnt,
  output logic [15:0] bad_cnt,
  output logic [7:0]  to_cnt,
  output logic [3:0]  st
);

  state_e      st_q, st_d;
  logic [15:0] tmo_q, tmo_d;
  logic [3:0]  gap_q, gap_d;
  logic [11:0] drn_q, drn_d;
  logic        rcv_q, rcv_d;
  logic        drain_q, drain_d;
  logic        cfg_stb_q, cfg_stb_d;
  logic        ok_inc, bad_inc, to_inc;
  logic [11:0] issued;
  logic        more;

  always_comb begin
    st_d      = st_q;
    tmo_d     = tmo_q;
    gap_d     = '0;
    drn_d     = drn_q;
    rcv_d     = 1'b0;
    drain_d   = 1'b0;
    cfg_stb_d = 1'b0;
    ok_inc    = 1'b0;
    bad_inc   = 1'b0;
    to_inc    = 1'b0;
    // The strobe in flight this cycle has not yet been reflected in fifoc_cnt.
    issued    = drn_q + {11'b0, drain_q};
    more      = fifoc_cnt > {11'b0, drain_q};
    case (st_q)
      SC_IDLE: begin
        tmo_d = '0;
        if (en && fifoc_cnt >= FRAME_LEN) st_d = SC_ARM;
      end
      SC_ARM: begin
        tmo_d = tmo_q + 16'd1;
        st_d  = SC_WAIT;
      end
      SC_WAIT: begin
        tmo_d = tmo_q + 16'd1;
        if (prs_fd) begin
          st_d      = SC_EVAL;
          cfg_stb_d = !prs_err;
        end else if (tmo_q == TIMEOUT - 16'd1) begin
          st_d = SC_RECOV;
        end
      end
      SC_EVAL: begin
        tmo_d   = '0;
        ok_inc  = cfg_stb_q;
        bad_inc = !cfg_stb_q;
        st_d    = SC_RELS;
      end
      SC_RELS: begin
        tmo_d = tmo_q + 16'd1;
        if (!prs_fd)                           st_d = SC_HOLD;
        else if (tmo_q == TIMEOUT - 16'd1)     st_d = SC_RECOV;
      end
      SC_HOLD: begin
        gap_d = gap_q + 4'd1;
        if ({1'b0, gap_q} + 5'd1 >= {1'b0, GAP}) st_d = SC_IDLE;
      end
      SC_RECOV: begin
        rcv_d  = 1'b1;
        to_inc = !rcv_q;
        drn_d  = '0;
        if (rcv_q) st_d = SC_DRAIN;
      end
      SC_DRAIN: begin
        drn_d = issued;
        if (more && issued < FRAME_LEN) drain_d = 1'b1;
        else                            st_d    = SC_HOLD;
      end
      default: st_d = SC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= SC_IDLE;
      tmo_q     <= '0;
      gap_q     <= '0;
      drn_q     <= '0;
      rcv_q     <= 1'b0;
      drain_q   <= 1'b0;
      cfg_stb_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      drn_q     <= drn_d;
      rcv_q     <= rcv_d;
      drain_q   <= drain_d;
      cfg_stb_q <= cfg_stb_d;
    end
  end

  sat_cnt #(.W(16)) u_ok  (.clk(clk), .rst_n(rst), .inc(ok_inc),  .cnt(ok_cnt));
  sat_cnt #(.W(16)) u_bad (.clk(clk), .rst_n(rst), .inc(bad_inc), .cnt(bad_cnt));
  sat_cnt #(.W(8))  u_to  (.clk(clk), .rst_n(rst), .inc(to_inc),  .cnt(to_cnt));

  assign st          = st_q;
  assign busy        = (st_q != SC_IDLE);
  assign prs_fs      = (st_q == SC_WAIT);
  assign prs_rst     = (st_q == SC_RECOV);
  assign fifoc_drain = drain_q;
  assign cfg_stb     = cfg_stb_q;
  assign data_len    = FRAME_LEN;

endmodule

// File: tb/tb_cmd_sched.sv
// Directed bench for cmd_sched with FRAME_LEN=11, TIMEOUT=64, GAP=4.
module tb_cmd_sched;

  logic        clk, rst, en, prs_fd, prs_err;
  logic [11:0] fifoc_cnt;
  logic        fifoc_drain, prs_fs, prs_rst, cfg_stb, busy;
  logic [11:0] data_len;
  logic [15:0] ok_cnt, bad_cnt;
  logic [7:0]  to_cnt;
  logic [3:0]  st;

  int vecs = 0;
  int errs = 0;

  cmd_sched #(.FRAME_LEN(12'd11), .TIMEOUT(16'd64), .GAP(4'd4)) dut (
    .clk(clk), .rst(rst), .en(en), .fifoc_cnt(fifoc_cnt), .fifoc_drain(fifoc_drain),
    .prs_fs(prs_fs), .prs_fd(prs_fd), .prs_err(prs_err), .prs_rst(prs_rst),
    .data_len(data_len), .cfg_stb(cfg_stb), .busy(busy), .ok_cnt(ok_cnt),
    .bad_cnt(bad_cnt), .to_cnt(to_cnt), .st(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b0; en = 1'b0; fifoc_cnt = '0; prs_fd = 1'b0; prs_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_st(input logic [3:0] s, input int budget, output int n);
    n = 0;
    while (st !== s && n < budget) begin @(negedge clk); n++; end
  endtask

  // Full good/bad frame: parser answers 20 cycles after prs_fs is seen.
  task automatic run_frame(input logic err, output int lat, output int drop,
                           output logic [3:0] st_eval, output logic stb_eval,
                           output logic [3:0] st_rels, output logic stb_rels, output int hold);
    @(negedge clk); en = 1'b1; fifoc_cnt = 12'd11; lat = 0;
    while (prs_fs !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    fifoc_cnt = '0; drop = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (prs_fs !== 1'b1) drop++; end
    prs_fd = 1'b1; prs_err = err;
    @(negedge clk); st_eval = st; stb_eval = cfg_stb; prs_fd = 1'b0; prs_err = 1'b0;
    @(negedge clk); st_rels = st; stb_rels = cfg_stb;
    hold = 0;
    @(negedge clk);
    while (st === 4'd5 && hold < 20) begin hold++; @(negedge clk); end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; fifoc_cnt = '0; prs_fd = 1'b0; prs_err = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if ({st, busy, prs_fs, prs_rst, fifoc_drain, cfg_stb} !== 9'b0) begin
      errs++; $display("FAIL reset_ctrl: got st=%0d busy=%b fs=%b rst=%b drn=%b stb=%b, want all 0",
                       st, busy, prs_fs, prs_rst, fifoc_drain, cfg_stb); end
    vecs++; if ({ok_cnt, bad_cnt, to_cnt} !== 40'd0) begin
      errs++; $display("FAIL reset_cnts: got ok=%0d bad=%0d to=%0d, want 0", ok_cnt, bad_cnt, to_cnt); end
    vecs++; if (data_len !== 12'd11) begin
      errs++; $display("FAIL reset_data_len: got %0d, want 11", data_len); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good();
    int lat, drop, hold; logic [3:0] se, sr; logic be, br;
    apply_reset();
    run_frame(1'b0, lat, drop, se, be, sr, br, hold);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL good_fs_latency: got %0d edges, want 2", lat); end
    vecs++; if (drop !== 0) begin errs++; $display("FAIL good_fs_held: got %0d low cycles, want 0", drop); end
    vecs++; if (se !== 4'd3 || be !== 1'b1) begin
      errs++; $display("FAIL good_eval: got st=%0d stb=%b, want st=3 stb=1", se, be); end
    vecs++; if (sr !== 4'd4 || br !== 1'b0) begin
      errs++; $display("FAIL good_rels: got st=%0d stb=%b, want st=4 stb=0", sr, br); end
    vecs++; if (hold !== 4 || st !== 4'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL good_hold: got hold=%0d st=%0d busy=%b, want 4 0 0", hold, st, busy); end
    vecs++; if (ok_cnt !== 16'd1 || bad_cnt !== 16'd0) begin
      errs++; $display("FAIL good_counts: got ok=%0d bad=%0d, want 1 0", ok_cnt, bad_cnt); end
  endtask

  task automatic test_bad();
    int lat, drop, hold; logic [3:0] se, sr; logic be, br;
    apply_reset();
    run_frame(1'b1, lat, drop, se, be, sr, br, hold);
    vecs++; if (se !== 4'd3 || be !== 1'b0 || br !== 1'b0) begin
      errs++; $display("FAIL bad_no_stb: got st=%0d stb=%b/%b, want st=3 stb=0/0", se, be, br); end
    vecs++; if (ok_cnt !== 16'd0 || bad_cnt !== 16'd1 || to_cnt !== 8'd0) begin
      errs++; $display("FAIL bad_counts: got ok=%0d bad=%0d to=%0d, want 0 1 0", ok_cnt, bad_cnt, to_cnt); end
    vecs++; if (hold !== 4 || st !== 4'd0) begin
      errs++; $display("FAIL bad_hold: got hold=%0d st=%0d, want 4 0", hold, st); end
  endtask

  // Hung parser; optionally the FIFO holds fewer bytes by the time of the drain.
  task automatic hung_frame(input logic [11:0] left, output int k, output int r,
                            output int d, output logic [7:0] to_seen);
    int n, g; logic prev;
    @(negedge clk); en = 1'b1; fifoc_cnt = 12'd11;
    wait_st(4'd1, 10, n);
    en = 1'b0; fifoc_cnt = left;
    k = 0;
    while (st !== 4'd6 && k < 200) begin @(negedge clk); k++; end
    r = 0; g = 0;
    while (st === 4'd6 && g < 10) begin if (prs_rst === 1'b1) r++; g++; @(negedge clk); end
    to_seen = to_cnt;
    d = 0; g = 0; prev = 1'b0;
    while (st === 4'd7 && g < 50) begin
      if (prev) fifoc_cnt = fifoc_cnt - 12'd1;
      prev = fifoc_drain;
      if (fifoc_drain === 1'b1) d++;
      g++; @(negedge clk);
    end
    if (prev) fifoc_cnt = fifoc_cnt - 12'd1;
    wait_st(4'd0, 20, n);
  endtask

  task automatic test_timeout();
    int k, r, d; logic [7:0] ts;
    apply_reset();
    hung_frame(12'd11, k, r, d, ts);
    vecs++; if (k !== 64) begin errs++; $display("FAIL to_recov_cycle: got %0d, want 64", k); end
    vecs++; if (r !== 2) begin errs++; $display("FAIL to_prs_rst_len: got %0d, want 2", r); end
    vecs++; if (ts !== 8'd1) begin errs++; $display("FAIL to_cnt: got %0d, want 1", ts); end
    vecs++; if (d !== 11) begin errs++; $display("FAIL to_drain_full: got %0d strobes, want 11", d); end
    vecs++; if (st !== 4'd0 || ok_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
      errs++; $display("FAIL to_end: got st=%0d ok=%0d bad=%0d, want 0 0 0", st, ok_cnt, bad_cnt); end
  endtask

  task automatic test_drain_partial();
    int k, r, d; logic [7:0] ts;
    apply_reset();
    hung_frame(12'd5, k, r, d, ts);
    vecs++; if (d !== 5) begin errs++; $display("FAIL drain_partial: got %0d strobes, want 5", d); end
    vecs++; if (fifoc_cnt !== 12'd0 || st !== 4'd0) begin
      errs++; $display("FAIL drain_partial_end: got fifo=%0d st=%0d, want 0 0", fifoc_cnt, st); end
  endtask

  task automatic test_underfill();
    int bad_cyc;
    apply_reset();
    en = 1'b1; fifoc_cnt = 12'd10; bad_cyc = 0;
    repeat (12) begin @(negedge clk); if (st !== 4'd0 || busy !== 1'b0 || prs_fs !== 1'b0) bad_cyc++; end
    vecs++; if (bad_cyc !== 0) begin errs++; $display("FAIL underfill: got %0d active cycles, want 0", bad_cyc); end
    en = 1'b0; fifoc_cnt = 12'd11; bad_cyc = 0;
    repeat (6) begin @(negedge clk); if (busy !== 1'b0) bad_cyc++; end
    vecs++; if (bad_cyc !== 0) begin errs++; $display("FAIL disabled: got %0d busy cycles, want 0", bad_cyc); end
    fifoc_cnt = '0;
  endtask

  task automatic test_collision();
    int n; logic [3:0] s63;
    apply_reset();
    @(negedge clk); en = 1'b1; fifoc_cnt = 12'd11;
    wait_st(4'd1, 10, n);
    fifoc_cnt = '0;
    repeat (63) @(negedge clk);
    s63 = st;
    prs_fd = 1'b1; prs_err = 1'b0;
    @(negedge clk);
    vecs++; if (s63 !== 4'd2 || st !== 4'd3 || cfg_stb !== 1'b1) begin
      errs++; $display("FAIL collide_eval: got st63=%0d st64=%0d stb=%b, want 2 3 1", s63, st, cfg_stb); end
    prs_fd = 1'b0;
    wait_st(4'd0, 20, n);
    vecs++; if (to_cnt !== 8'd0 || ok_cnt !== 16'd1 || st !== 4'd0) begin
      errs++; $display("FAIL collide_counts: got to=%0d ok=%0d st=%0d, want 0 1 0", to_cnt, ok_cnt, st); end
  endtask

  task automatic test_reset_mid();
    int lat, drop, hold, n; logic [3:0] se, sr; logic be, br;
    apply_reset();
    run_frame(1'b0, lat, drop, se, be, sr, br, hold);
    @(negedge clk); en = 1'b1; fifoc_cnt = 12'd11;
    wait_st(4'd2, 10, n);
    repeat (3) @(negedge clk);
    vecs++; if (st !== 4'd2 || ok_cnt !== 16'd1) begin
      errs++; $display("FAIL rstmid_pre: got st=%0d ok=%0d, want 2 1", st, ok_cnt); end
    rst = 1'b0;
    #1;
    vecs++; if ({st, busy, prs_fs, prs_rst, fifoc_drain, cfg_stb} !== 9'b0) begin
      errs++; $display("FAIL rstmid_ctrl: got st=%0d busy=%b fs=%b, want 0 0 0", st, busy, prs_fs); end
    vecs++; if ({ok_cnt, bad_cnt, to_cnt} !== 40'd0 || data_len !== 12'd11) begin
      errs++; $display("FAIL rstmid_cnts: got ok=%0d bad=%0d to=%0d len=%0d, want 0 0 0 11",
                       ok_cnt, bad_cnt, to_cnt, data_len); end
    en = 1'b0; fifoc_cnt = '0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    int n; logic [7:0] at255; logic stuck;
    apply_reset();
    en = 1'b1; at255 = '0; stuck = 1'b0;
    for (int i = 0; i < 256; i++) begin
      fifoc_cnt = 12'd11;
      wait_st(4'd1, 10, n);
      fifoc_cnt = '0;
      wait_st(4'd0, 200, n);
      if (st !== 4'd0) begin stuck = 1'b1; break; end
      if (i == 254) at255 = to_cnt;
    end
    en = 1'b0;
    vecs++; if (stuck !== 1'b0) begin errs++; $display("FAIL sat_progress: got stuck st=%0d, want idle", st); end
    vecs++; if (at255 !== 8'hFF) begin errs++; $display("FAIL sat_reach: got %0d, want 255", at255); end
    vecs++; if (to_cnt !== 8'hFF) begin errs++; $display("FAIL sat_hold: got %0d, want 255", to_cnt); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad();
    test_timeout();
    test_drain_partial();
    test_underfill();
    test_collision();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
